// File: rtl/usonic_pkg.sv
// Shared definitions for the ultrasonic echo time-of-flight detector.
// Holds the measurement state encoding and the default parameter values.
package usonic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    localparam int DEF_DATA_W     = 30;
    localparam int DEF_CNT_W      = 20;
    localparam int DEF_HOLDOFF    = 7000;
    localparam int DEF_MAX_WINDOW = 980000;
    localparam int DEF_N_CONSEC   = 3;

endpackage

// File: rtl/abs_sat.sv
// Saturating magnitude of a signed sample, one bit narrower than the input.
// The most-negative input has no positive counterpart, so it maps to all-ones.
module abs_sat #(
    parameter int W = 30
) (
    input  logic [W-1:0] din,
    output logic [W-2:0] mag
);

    // Low bits of -din depend only on low bits of din, so negate the narrow slice.
    always_comb begin
        if (!din[W-1]) begin
            mag = din[W-2:0];
        end else if (din[W-2:0] == '0) begin
            mag = '1;
        end else begin
            mag = ~din[W-2:0] + (W-1)'(1);
        end
    end

endmodule

// File: rtl/echo_tof_detector.sv
// Measures time from burst start to echo onset: blanks for HOLDOFF cycles, then
// looks for N_CONSEC consecutive valid samples at or above THRESH, or times out.
module echo_tof_detector
    import usonic_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int HOLDOFF    = DEF_HOLDOFF,
    parameter int MAX_WINDOW = DEF_MAX_WINDOW,
    parameter int N_CONSEC   = DEF_N_CONSEC
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic              ENA,
    input  logic              BURST_START,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    input  logic [DATA_W-2:0] THRESH,
    output logic [CNT_W-1:0]  TOF,
    output logic [DATA_W-2:0] PEAK,
    output logic              TOF_VALID,
    output logic              TIMEOUT,
    output logic              BUSY
);

    localparam int RUN_W = $clog2(N_CONSEC + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [CNT_W-1:0]   onset_q, onset_d;
    logic [DATA_W-2:0]  peak_q, peak_d;
    logic [CNT_W-1:0]   tof_q, tof_d;
    logic [DATA_W-2:0]  pk_out_q, pk_out_d;
    logic               tof_valid_q, tof_valid_d;
    logic               timeout_q, timeout_d;

    logic [DATA_W-2:0]  mag;
    logic [DATA_W-2:0]  peak_upd;
    logic [CNT_W-1:0]   cnt_inc;
    logic [RUN_W-1:0]   run_inc;
    logic               over;
    logic               detect;

    abs_sat #(.W(DATA_W)) u_abs_sat (
        .din (DIN),
        .mag (mag)
    );

    always_comb begin
        over     = DIN_VALID && (mag >= THRESH);
        peak_upd = (mag > peak_q) ? mag : peak_q;
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        run_inc  = run_q + RUN_W'(1);

        state_d     = state_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        onset_d     = onset_q;
        peak_d      = peak_q;
        tof_d       = tof_q;
        pk_out_d    = pk_out_q;
        tof_valid_d = 1'b0;
        timeout_d   = 1'b0;
        detect      = 1'b0;

        // Disable beats everything; a burst start in any state (re)starts a measurement.
        if (!ENA) begin
            state_d = ST_IDLE;
        end else if (BURST_START) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            run_d   = '0;
            onset_d = '0;
            peak_d  = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    cnt_d = cnt_inc;
                    if (DIN_VALID) begin
                        peak_d = peak_upd;
                        if (over) begin
                            run_d = run_inc;
                            if (run_q == '0) begin
                                onset_d = cnt_q;
                            end
                            if (run_inc == RUN_W'(N_CONSEC)) begin
                                detect      = 1'b1;
                                tof_d       = (run_q == '0) ? cnt_q : onset_q;
                                pk_out_d    = peak_upd;
                                tof_valid_d = 1'b1;
                                run_d       = '0;
                                state_d     = ST_IDLE;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                    // A detection on the final window cycle takes precedence over timeout.
                    if (!detect && cnt_q == CNT_W'(MAX_WINDOW - 1)) begin
                        timeout_d = 1'b1;
                        run_d     = '0;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            run_q       <= '0;
            onset_q     <= '0;
            peak_q      <= '0;
            tof_q       <= '0;
            pk_out_q    <= '0;
            tof_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            onset_q     <= onset_d;
            peak_q      <= peak_d;
            tof_q       <= tof_d;
            pk_out_q    <= pk_out_d;
            tof_valid_q <= tof_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign TOF       = tof_q;
    assign PEAK      = pk_out_q;
    assign TOF_VALID = tof_valid_q;
    assign TIMEOUT   = timeout_q;
    assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_echo_tof_detector.sv
// Directed bench for echo_tof_detector: expected pulses are queued as stimulus is
// driven and compared, with timing, when the DUT raises TOF_VALID or TIMEOUT.
module tb_echo_tof_detector;

    localparam int DATA_W     = 30;
    localparam int CNT_W      = 20;
    localparam int HOLDOFF    = 100;
    localparam int MAX_WINDOW = 2000;
    localparam int N_CONSEC   = 3;

    logic              SYS_CLK = 1'b0;
    logic              RST = 1'b1;
    logic              ENA = 1'b0;
    logic              BURST_START = 1'b0;
    logic [DATA_W-1:0] DIN = '0;
    logic              DIN_VALID = 1'b0;
    logic [DATA_W-2:0] THRESH = '0;
    logic [CNT_W-1:0]  TOF;
    logic [DATA_W-2:0] PEAK;
    logic              TOF_VALID;
    logic              TIMEOUT;
    logic              BUSY;

    echo_tof_detector #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .HOLDOFF    (HOLDOFF),
        .MAX_WINDOW (MAX_WINDOW),
        .N_CONSEC   (N_CONSEC)
    ) dut (
        .SYS_CLK     (SYS_CLK),
        .RST         (RST),
        .ENA         (ENA),
        .BURST_START (BURST_START),
        .DIN         (DIN),
        .DIN_VALID   (DIN_VALID),
        .THRESH      (THRESH),
        .TOF         (TOF),
        .PEAK        (PEAK),
        .TOF_VALID   (TOF_VALID),
        .TIMEOUT     (TIMEOUT),
        .BUSY        (BUSY)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct {
        bit                is_timeout;
        int                cyc;
        logic [CNT_W-1:0]  tof;
        logic [DATA_W-2:0] peak;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc = 0;
    int burst_edge = 0;
    logic [CNT_W-1:0]  last_tof  = '0;
    logic [DATA_W-2:0] last_peak = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge SYS_CLK);
        #1;
        cyc++;
    endtask

    task automatic burst();
        BURST_START = 1'b1;
        step();
        BURST_START = 1'b0;
        burst_edge = cyc;
    endtask

    task automatic advance_to(input int c);
        while ((cyc - burst_edge) < c) step();
    endtask

    task automatic sample_at(input int c, input logic [DATA_W-1:0] val);
        advance_to(c);
        DIN = val;
        DIN_VALID = 1'b1;
        step();
        DIN_VALID = 1'b0;
        DIN = '0;
    endtask

    task automatic expect_det(input int c_last, input logic [CNT_W-1:0] tof,
                              input logic [DATA_W-2:0] peak);
        exp_t e;
        e.is_timeout = 1'b0;
        e.cyc  = burst_edge + c_last + 1;
        e.tof  = tof;
        e.peak = peak;
        exp_q.push_back(e);
        last_tof  = tof;
        last_peak = peak;
    endtask

    task automatic expect_timeout();
        exp_t e;
        e.is_timeout = 1'b1;
        e.cyc  = burst_edge + MAX_WINDOW;
        e.tof  = last_tof;
        e.peak = last_peak;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("pending_pulses", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    // Every output pulse must match the head of the scoreboard in kind, time and value.
    always @(negedge SYS_CLK) begin
        if (TOF_VALID || TIMEOUT) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 64'({TOF_VALID, TIMEOUT}), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_exclusive", 64'(TOF_VALID & TIMEOUT), 64'd0);
                check("pulse_kind",  64'(TIMEOUT), 64'(e.is_timeout));
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("tof",  64'(TOF),  64'(e.tof));
                check("peak", 64'(PEAK), 64'(e.peak));
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] most_neg;
        most_neg = '0;
        most_neg[DATA_W-1] = 1'b1;

        // Reset state, with a burst start that reset must override.
        RST = 1'b1;
        BURST_START = 1'b1;
        ENA = 1'b1;
        step();
        step();
        BURST_START = 1'b0;
        RST = 1'b0;
        check("rst_tof", 64'(TOF), 64'd0);
        check("rst_peak", 64'(PEAK), 64'd0);
        check("rst_tof_valid", 64'(TOF_VALID), 64'd0);
        check("rst_timeout", 64'(TIMEOUT), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        THRESH = DATA_W'(1000) - 1'b1 + 1'b1;

        // Basic echo: three strong samples after blanking.
        burst();
        check("busy_blank", 64'(BUSY), 64'd1);
        expect_det(540, 20'd500, 29'd2000);
        sample_at(500, 30'd2000);
        sample_at(520, 30'd2000);
        sample_at(540, 30'd2000);
        drain(10);
        check("busy_after_det", 64'(BUSY), 64'd0);

        // A weak sample breaks the run; onset moves to the next strong sample.
        burst();
        expect_det(580, 20'd540, 29'd3000);
        sample_at(500, 30'd2000);
        sample_at(520, 30'd500);
        sample_at(540, 30'd2000);
        sample_at(560, 30'd3000);
        sample_at(580, 30'd2500);
        drain(10);

        // Strong samples inside blanking are ignored, so the window times out.
        burst();
        expect_timeout();
        sample_at(50, 30'd5000);
        sample_at(60, 30'd5000);
        sample_at(70, 30'd5000);
        drain(MAX_WINDOW + 100);
        check("tof_kept_after_timeout", 64'(TOF), 64'd540);

        // Most-negative input saturates to the all-ones magnitude.
        THRESH = '1;
        burst();
        expect_det(220, 20'd200, '1);
        sample_at(200, most_neg);
        sample_at(210, most_neg);
        sample_at(220, most_neg);
        drain(10);
        THRESH = 29'd1000;

        // Restart mid-measurement: earlier run and peak must be discarded.
        burst();
        sample_at(150, 30'd2000);
        sample_at(160, 30'd2000);
        advance_to(300);
        burst();
        expect_det(540, 20'd500, 29'd1500);
        sample_at(500, 30'd1500);
        sample_at(520, 30'd1500);
        sample_at(540, 30'd1500);
        drain(10);

        // Detection on the last window cycle wins over timeout.
        burst();
        expect_det(MAX_WINDOW - 1, CNT_W'(MAX_WINDOW - 3), 29'd2000);
        sample_at(MAX_WINDOW - 3, 30'd2000);
        sample_at(MAX_WINDOW - 2, 30'd2000);
        sample_at(MAX_WINDOW - 1, 30'd2000);
        drain(10);

        // Dropping enable abandons the measurement silently.
        burst();
        sample_at(150, 30'd2000);
        sample_at(160, 30'd2000);
        advance_to(170);
        ENA = 1'b0;
        step();
        ENA = 1'b1;
        check("busy_after_ena_low", 64'(BUSY), 64'd0);
        sample_at(180, 30'd2000);
        sample_at(190, 30'd2000);
        sample_at(200, 30'd2000);
        step();
        check("tof_kept_after_ena", 64'(TOF), 64'(last_tof));
        check("peak_kept_after_ena", 64'(PEAK), 64'(last_peak));

        // Reset mid-measurement clears outputs and ignores later echoes.
        burst();
        sample_at(200, 30'd2000);
        sample_at(210, 30'd2000);
        advance_to(400);
        RST = 1'b1;
        step();
        RST = 1'b0;
        last_tof  = '0;
        last_peak = '0;
        check("midrst_tof", 64'(TOF), 64'd0);
        check("midrst_peak", 64'(PEAK), 64'd0);
        check("midrst_busy", 64'(BUSY), 64'd0);
        check("midrst_tof_valid", 64'(TOF_VALID), 64'd0);
        check("midrst_timeout", 64'(TIMEOUT), 64'd0);
        sample_at(420, 30'd2000);
        sample_at(440, 30'd2000);
        sample_at(460, 30'd2000);
        repeat (20) step();
        check("busy_idle_end", 64'(BUSY), 64'd0);
        check("tof_idle_end", 64'(TOF), 64'd0);
        check("queue_empty_end", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
